// File: rtl/sensor_drain_sched.sv
// sensor_drain_sched: frame sequencer for the high-speed sensor buffer.
// Enables capture, waits for buffer-full, streams every buffered word to a
// destination address over a valid/ready write port, then clears the buffer.
// Optional build macro SENSOR_DRAIN_CONT_EN: back-to-back frames with
// cont_stop input and frame_cnt output.
module sensor_drain_sched #(
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              sctrl_en,
  output logic              sctrl_clear,
  output logic [IDX_W-1:0]  sctrl_addr,
  input  logic              sctrl_interrupt,
  input  logic [31:0]       sctrl_out,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef SENSOR_DRAIN_CONT_EN
  ,
  input  logic              cont_stop,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_CLEAR,
    S_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  base;
  logic [IDX_W-1:0]   idx;
  logic               abort_pend;

  logic               start_acc;
  logic               beat_acc;
  logic               abort_set;
  logic               cont_go;

  // Byte address of a buffer word; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  i);
    return b + ADDR_W'({i, 2'b00});
  endfunction

  // State register; a reset mid-frame simply drops the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    beat_acc    = 1'b0;
    abort_set   = 1'b0;
    cont_go     = 1'b0;
    sctrl_en    = 1'b0;
    sctrl_clear = 1'b0;
    wr_valid    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        sctrl_en = 1'b1;
        // Abort wins over a simultaneous buffer-full.
        if (abort) begin
          abort_set = 1'b1;
          state_nxt = S_CLEAR;
        end else if (sctrl_interrupt) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wr_valid = 1'b1;
        // The presented beat is never withdrawn; an abort takes effect only
        // once that beat has been accepted.
        if (wr_ready) begin
          beat_acc = 1'b1;
          if (abort || abort_pend) begin
            abort_set = 1'b1;
            state_nxt = S_CLEAR;
          end else if (idx == IDX_LAST) begin
            state_nxt = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        sctrl_clear = 1'b1;
        state_nxt   = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
`ifdef SENSOR_DRAIN_CONT_EN
        if (!aborted && !cont_stop) begin
          cont_go   = 1'b1;
          state_nxt = S_FILL;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame base address and buffer read index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base <= '0;
      idx  <= '0;
    end else if (start_acc) begin
      base <= dst_base;
      idx  <= '0;
    end else if (cont_go) begin
      base <= base + FRAME_BYTES;
      idx  <= '0;
    end else if (beat_acc) begin
      idx  <= idx + 1'b1;
    end
  end

  // Remembers an abort seen while a beat is stalled, until that beat lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          abort_pend <= 1'b0;
    else if (state == S_DRAIN && state_nxt == S_DRAIN)  abort_pend <= abort_pend | abort;
    else                                                abort_pend <= 1'b0;
  end

  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          aborted <= 1'b0;
    else if (start_acc) aborted <= 1'b0;
    else if (abort_set) aborted <= 1'b1;
  end

`ifdef SENSOR_DRAIN_CONT_EN
  // Counts every completed frame, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              frame_cnt <= '0;
    else if (state == S_FIN) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

  // Write-port datapath; driven only while draining, zero otherwise.
  always_comb begin
    sctrl_addr = '0;
    wr_addr    = '0;
    wr_data    = '0;
    if (wr_valid) begin
      sctrl_addr = idx;
      wr_addr    = byte_addr(base, idx);
      wr_data    = DATA_W'(sctrl_out);
    end
  end

endmodule

// File: tb/tb_sensor_drain_sched.sv
// tb_sensor_drain_sched: table-driven frames plus hand sequences for the
// sensor drain sequencer, with a sensor-buffer model and a write-port
// scoreboard (address = base + 4*i, data = buffer word i).
`timescale 1ns/1ps
module tb_sensor_drain_sched;

  localparam int DEPTH  = 4096;
  localparam int IDX_W  = 12;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic              sctrl_en, sctrl_clear;
  logic [IDX_W-1:0]  sctrl_addr;
  logic              sctrl_interrupt = 1'b0;
  logic [31:0]       sctrl_out;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy, done, aborted;
`ifdef SENSOR_DRAIN_CONT_EN
  logic              cont_stop = 1'b1;
  logic [15:0]       frame_cnt;
`endif

  logic [31:0] mem [DEPTH];
  assign sctrl_out = mem[sctrl_addr];

  sensor_drain_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .dst_base(dst_base),
    .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
    .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef SENSOR_DRAIN_CONT_EN
    , .cont_stop(cont_stop), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (after the model drivers).
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Scoreboard state
  int          beat_cnt = 0;
  int          fbeat = 0;
  int          clear_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_base = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  // Ready driver: 0 always high, 1 random, 2 low, 3 low only while beat stall_at is presented
  int rdy_mode = 0;
  int stall_at = -1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'($urandom_range(0, 1));
      2:       wr_ready = 1'b0;
      default: wr_ready = (fbeat != stall_at);
    endcase
  end

  // Sensor buffer model: raises buffer-full after fill_lat capture cycles, drops it on clear
  int fill_cnt = 0;
  int fill_lat = 20;
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      sctrl_interrupt = 1'b0;
      fill_cnt = 0;
    end else if (sctrl_clear) begin
      sctrl_interrupt = 1'b0;
      fill_cnt = 0;
    end else if (sctrl_en) begin
      fill_cnt++;
      if (fill_cnt >= fill_lat) sctrl_interrupt = 1'b1;
    end
  end

  // Write-port monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(wr_valid), 32'd1);
        chk("stall_addr", wr_addr, prev_addr);
        chk("stall_data", wr_data, prev_data);
      end
      if (wr_valid) begin
        chk("rd_index", 32'(sctrl_addr), 32'(fbeat % DEPTH));
        chk("en_during_drain", 32'(sctrl_en), 32'd0);
      end else begin
        chk("idle_index", 32'(sctrl_addr), 32'd0);
      end
      if (wr_valid && wr_ready) begin
        chk("beat_addr", wr_addr, exp_base + 32'(fbeat * 4));
        chk("beat_data", wr_data, mem[fbeat % DEPTH]);
        if (exp_base == 32'hFFFF_FFF0 && fbeat == 4) chk("wrap_addr", wr_addr, 32'h0);
        beat_cnt++;
        fbeat++;
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (sctrl_clear) clear_cnt++;
      if (done) begin
        done_cnt++;
        fbeat = 0;
`ifdef SENSOR_DRAIN_CONT_EN
        if (!cont_stop && !aborted) exp_base = exp_base + 32'h4000;
`endif
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_en"}, 32'(sctrl_en), 0);
    chk({tag, "_clear"}, 32'(sctrl_clear), 0);
    chk({tag, "_addr"}, 32'(sctrl_addr), 0);
    chk({tag, "_valid"}, 32'(wr_valid), 0);
    chk({tag, "_waddr"}, wr_addr, 0);
    chk({tag, "_wdata"}, wr_data, 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
  endtask

  task automatic start_frame(input logic [31:0] b, input int mode);
    beat_cnt = 0; clear_cnt = 0; done_cnt = 0; fbeat = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rdy_mode = mode;
    exp_base = b;
    dst_base = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    dst_base = $urandom;
    chk("busy_after_start", 32'(busy), 1);
    chk("aborted_cleared", 32'(aborted), 0);
  endtask

  task automatic wait_done(input int n, input int limit);
    int g;
    g = 0;
    while (done_cnt < n && g < limit) begin
      tick(1);
      g++;
    end
    chk("done_seen", 32'(done_cnt >= n), 1);
  endtask

  typedef struct {
    logic [31:0] base;
    int          rdy_mode;
    int          abort_at;
    bit          abort_fill;
    bit          ign_start;
    int          exp_beats;
    logic        exp_aborted;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int g;
    vecs[0] = '{32'h1000_0000, 0,  -1, 1'b0, 1'b0, 4096, 1'b0};
    vecs[1] = '{32'h3000_0000, 1, 700, 1'b0, 1'b0,  701, 1'b1};
    vecs[2] = '{32'h2000_0100, 1,  -1, 1'b0, 1'b0, 4096, 1'b0};
    vecs[3] = '{32'h0000_4444, 0,  -1, 1'b1, 1'b0,    0, 1'b1};
    vecs[4] = '{32'hFFFF_FFF0, 0,  -1, 1'b0, 1'b1, 4096, 1'b0};
    vecs[5] = '{32'h5000_0000, 0,   0, 1'b0, 1'b0,    1, 1'b1};
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    #3 rstn = 1'b0;
    #1 check_zero("reset");
    tick(3);
    rstn = 1'b1;
    tick(2);
    check_zero("idle");

    // Table-driven frames
    foreach (vecs[k]) begin
      start_frame(vecs[k].base, vecs[k].rdy_mode);
      if (vecs[k].abort_fill) begin
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
      end
      if (vecs[k].ign_start) begin
        repeat (3) begin
          tick(50);
          start = 1'b1;
          dst_base = 32'hDEAD_0000;
          tick(1);
          start = 1'b0;
        end
      end
      g = 0;
      while (done_cnt == 0 && g < 20000) begin
        if (vecs[k].abort_at >= 0 && fbeat == vecs[k].abort_at && wr_valid) abort = 1'b1;
        tick(1);
        g++;
      end
      abort = 1'b0;
      chk("frame_done", 32'(done_cnt != 0), 1);
      tick(3);
      chk("frame_beats", 32'(beat_cnt), 32'(vecs[k].exp_beats));
      chk("frame_clears", 32'(clear_cnt), 1);
      chk("frame_dones", 32'(done_cnt), 1);
      chk("frame_aborted", 32'(aborted), 32'(vecs[k].exp_aborted));
      chk("frame_idle", 32'(busy), 0);
    end

    // Abort raised while beat 100 is stalled
    stall_at = 100;
    start_frame(32'h6000_0000, 3);
    g = 0;
    while (!(fbeat == 100 && wr_valid) && g < 6000) begin
      tick(1);
      g++;
    end
    chk("reach_beat100", 32'(fbeat), 100);
    abort = 1'b1;
    tick(4);
    chk("abort_hold_valid", 32'(wr_valid), 1);
    chk("abort_hold_addr", wr_addr, 32'h6000_0190);
    chk("abort_hold_beats", 32'(beat_cnt), 100);
    rdy_mode = 0;
    wait_done(1, 100);
    abort = 1'b0;
    tick(3);
    chk("abort_beats", 32'(beat_cnt), 101);
    chk("abort_clears", 32'(clear_cnt), 1);
    chk("abort_dones", 32'(done_cnt), 1);
    chk("abort_sticky", 32'(aborted), 1);

    // Reset in the middle of a drain
    start_frame(32'h7000_0000, 0);
    g = 0;
    while (fbeat < 50 && g < 6000) begin
      tick(1);
      g++;
    end
    chk("reach_beat50", 32'(wr_valid), 1);
    rstn = 1'b0;
    #1 check_zero("midreset");
    tick(2);
    rstn = 1'b1;
    tick(3);
    chk("midreset_no_clear", 32'(clear_cnt), 0);
    chk("midreset_no_done", 32'(done_cnt), 0);
    chk("midreset_idle", 32'(busy), 0);

`ifdef SENSOR_DRAIN_CONT_EN
    // Two back-to-back frames, stopped by cont_stop during the second
    chk("cont_cnt_reset", 32'(frame_cnt), 0);
    cont_stop = 1'b0;
    start_frame(32'h0, 0);
    wait_done(1, 6000);
    cont_stop = 1'b1;
    wait_done(2, 6000);
    tick(5);
    chk("cont_beats", 32'(beat_cnt), 8192);
    chk("cont_clears", 32'(clear_cnt), 2);
    chk("cont_frames", 32'(frame_cnt), 2);
    chk("cont_idle", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
